// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multi-cycle RV32I core (fetch handshake, decode, sequencing, instret, illegal trap)
// Inputs:  clk_i, rst_i (sync, active high), instr_i (IR), zero_i (ALU zero), mem_ready_i (memory done)
// Outputs: memory request/we/iord, IR/PC/regfile strobes, ALU and write-back selects,
//          illegal_o (sticky until reset), state_o (debug), instret_o (retired count)
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      instr_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             pc_src_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             reg_write_o,
  output logic [1:0]       mem_to_reg_o,
  output logic             illegal_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret_o
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_ILL = 3'd5} state_t;
  typedef enum logic [2:0] {C_R, C_IALU, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_BAD} cls_t;
  state_t state;
  cls_t cls, dec;
  logic [6:0] op;
  logic [2:0] f3;
  logic run, ex, retire, unused;
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  // zero_i steers the PC in the datapath via pc_write_cond_o; the FSM itself never branches on it
  assign unused = ^{instr_i[31:15], instr_i[11:7], zero_i};
  always_comb
    dec = op == 7'b0110011                    ? C_R
        : op == 7'b0010011                    ? C_IALU
        : (op == 7'b0000011 && f3 == 3'b010)  ? C_LW
        : (op == 7'b0100011 && f3 == 3'b010)  ? C_SW
        : op == 7'b1100011                    ? C_BR
        : op == 7'b1101111                    ? C_JAL
        : (op == 7'b1100111 && f3 == 3'b000)  ? C_JALR
        :                                       C_BAD;
  // every path back to IF from EX/MEM/WB retires one instruction
  assign retire = (state == S_EX && cls == C_BR) || (state == S_MEM && mem_ready_i && cls == C_SW) || state == S_WB;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IF;
      cls       <= C_R;
      instret_o <= '0;
    end else begin
      if (retire) instret_o <= instret_o + CNT_W'(1);
      case (state)
        S_IF:    if (mem_ready_i) state <= S_ID;
        S_ID:    begin
          cls   <= dec;
          state <= dec == C_BAD ? S_ILL : S_EX;
        end
        S_EX:    state <= (cls == C_LW || cls == C_SW) ? S_MEM : cls == C_BR ? S_IF : S_WB;
        S_MEM:   if (mem_ready_i) state <= cls == C_LW ? S_WB : S_IF;
        S_WB:    state <= S_IF;
        S_ILL:   state <= S_ILL;
        default: state <= S_IF;
      endcase
    end
  end
  // strobes are gated by reset so an aborted instruction never writes anything
  assign run             = !rst_i;
  assign ex              = state == S_EX;
  assign mem_req_o       = run && (state == S_IF || state == S_MEM);
  assign mem_we_o        = state == S_MEM && cls == C_SW;
  assign iord_o          = state == S_MEM;
  assign ir_write_o      = run && state == S_IF && mem_ready_i;
  assign pc_write_o      = run && ((state == S_IF && mem_ready_i) || (ex && (cls == C_JAL || cls == C_JALR)));
  assign pc_write_cond_o = run && ex && cls == C_BR;
  assign pc_src_o        = ex && (cls == C_BR || cls == C_JAL);
  assign alu_src_a_o     = state == S_ID ? 2'd1 : (ex && cls != C_JAL) ? 2'd2 : 2'd0;
  assign alu_src_b_o     = state == S_IF ? 2'd1
                         : state == S_ID ? 2'd2
                         : (ex && (cls == C_IALU || cls == C_LW || cls == C_SW || cls == C_JALR)) ? 2'd2
                         : 2'd0;
  assign alu_op_o        = (ex && (cls == C_R || cls == C_IALU)) ? 2'b10 : (ex && cls == C_BR) ? 2'b01 : 2'b00;
  assign reg_write_o     = run && state == S_WB;
  assign mem_to_reg_o    = state != S_WB ? 2'd0 : cls == C_LW ? 2'd1 : (cls == C_JAL || cls == C_JALR) ? 2'd2 : 2'd0;
  assign illegal_o       = state == S_ILL;
  assign state_o         = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle model check of multicycle_ctrl plus literal latency/strobe expectations
module tb_multicycle_ctrl;
  localparam int W = 4;
  localparam int CR = 0, CIALU = 1, CLW = 2, CSW = 3, CBR = 4, CJAL = 5, CJALR = 6, CILL = 7;
  typedef struct packed {
    logic req, we, iord, irw, pcw, pcc, pcs;
    logic [1:0] sa, sb, op;
    logic rw;
    logic [1:0] m2r;
    logic ill;
    logic [2:0] st;
  } ctl_t;
  typedef struct { int ph; bit rdy; bit rst; } ent_t;
  logic clk = 0, rst_i = 1, zero_i = 0, mem_ready_i = 1;
  logic [31:0] instr_i = 32'h0;
  logic mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o, pc_src_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, mem_to_reg_o;
  logic reg_write_o, illegal_o;
  logic [2:0] state_o;
  logic [W-1:0] instret_o;
  int c_cmp = 0, c_fail = 0, l_cmp = 0, l_fail = 0;
  int n_rw = 0, n_iord = 0, n_we = 0, n_strb = 0;
  int cnt = 0, last_len, last_rw, last_iord, last_we, last_strb;
  bit chk = 0;
  ctl_t exp_c;
  int exp_cnt;
  always #5 clk = ~clk;
  multicycle_ctrl #(.CNT_W(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o), .ir_write_o(ir_write_o),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .pc_src_o(pc_src_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o), .illegal_o(illegal_o),
    .state_o(state_o), .instret_o(instret_o)
  );
  function automatic int cls_of(logic [31:0] i);
    case (i[6:0])
      7'b0110011: return CR;
      7'b0010011: return CIALU;
      7'b0000011: return i[14:12] == 3'b010 ? CLW : CILL;
      7'b0100011: return i[14:12] == 3'b010 ? CSW : CILL;
      7'b1100011: return CBR;
      7'b1101111: return CJAL;
      7'b1100111: return i[14:12] == 3'b000 ? CJALR : CILL;
      default:    return CILL;
    endcase
  endfunction
  // phase numbers are the architectural state encodings: IF=0 ID=1 EX=2 MEM=3 WB=4 ILL=5
  function automatic ctl_t model(int ph, int c, bit rdy, bit rst);
    ctl_t o = '0;
    o.st = 3'(ph);
    case (ph)
      0: begin o.req = 1; o.sb = 2'd1; o.irw = rdy; o.pcw = rdy; end
      1: begin o.sa = 2'd1; o.sb = 2'd2; end
      2: case (c)
        CR:       begin o.sa = 2'd2; o.op = 2'b10; end
        CIALU:    begin o.sa = 2'd2; o.sb = 2'd2; o.op = 2'b10; end
        CLW, CSW: begin o.sa = 2'd2; o.sb = 2'd2; end
        CBR:      begin o.sa = 2'd2; o.op = 2'b01; o.pcc = 1; o.pcs = 1; end
        CJAL:     begin o.pcw = 1; o.pcs = 1; end
        CJALR:    begin o.sa = 2'd2; o.sb = 2'd2; o.pcw = 1; end
        default:  ;
      endcase
      3: begin o.req = 1; o.iord = 1; o.we = c == CSW; end
      4: begin o.rw = 1; o.m2r = c == CLW ? 2'd1 : (c == CJAL || c == CJALR) ? 2'd2 : 2'd0; end
      5: o.ill = 1;
      default: ;
    endcase
    if (rst) begin o.req = 0; o.irw = 0; o.pcw = 0; o.pcc = 0; o.rw = 0; end
    if (!o.req) o.we = 0;
    return o;
  endfunction
  always @(negedge clk) begin
    if (chk) begin
      ctl_t act;
      act = {mem_req_o, mem_we_o & mem_req_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o, pc_src_o,
             alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o, mem_to_reg_o, illegal_o, state_o};
      c_cmp++;
      if (act !== exp_c) begin
        c_fail++;
        $display("FAIL ctl t=%0t got=%h want=%h", $time, act, exp_c);
      end
      c_cmp++;
      if (instret_o !== W'(exp_cnt)) begin
        c_fail++;
        $display("FAIL instret t=%0t got=%0d want=%0d", $time, instret_o, exp_cnt);
      end
      n_rw   += int'(reg_write_o);
      n_iord += int'(iord_o);
      n_we   += int'(mem_we_o & mem_req_o);
      n_strb += int'(state_o == 3'd5 && (mem_req_o | ir_write_o | pc_write_o | pc_write_cond_o | reg_write_o));
    end
  end
  task automatic lit(input string nm, input int got, input int want);
    l_cmp++;
    if (got != want) begin
      l_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask
  task automatic step(input ent_t e, input int c);
    @(posedge clk);
    #1;
    rst_i = e.rst;
    mem_ready_i = e.rdy;
    exp_c = model(e.ph, c, e.rdy, e.rst);
    exp_cnt = cnt;
    chk = 1;
  endtask
  task automatic run(input logic [31:0] ins, input int if_w, input int mem_w, input bit z, input bit abort);
    int c = cls_of(ins);
    int b_rw = n_rw, b_iord = n_iord, b_we = n_we, b_strb = n_strb;
    ent_t q[$];
    for (int k = 0; k < if_w; k++) q.push_back('{0, 1'b0, 1'b0});
    q.push_back('{0, 1'b1, 1'b0});
    q.push_back('{1, 1'($urandom_range(0, 1)), 1'b0});
    if (c == CILL) begin
      repeat (10) q.push_back('{5, 1'($urandom_range(0, 1)), 1'b0});
      q.push_back('{5, 1'b1, 1'b1});
    end else begin
      q.push_back('{2, 1'($urandom_range(0, 1)), 1'b0});
      if (c == CLW || c == CSW) begin
        for (int k = 0; k < mem_w; k++) q.push_back('{3, 1'b0, 1'b0});
        q.push_back('{3, 1'b1, abort});
      end
      if (!abort && c != CBR && c != CSW) q.push_back('{4, 1'($urandom_range(0, 1)), 1'b0});
    end
    instr_i = ins;
    zero_i = z;
    foreach (q[k]) step(q[k], c);
    @(negedge clk);
    #1;
    last_len = q.size();
    last_rw = n_rw - b_rw;
    last_iord = n_iord - b_iord;
    last_we = n_we - b_we;
    last_strb = n_strb - b_strb;
    cnt = (abort || c == CILL) ? 0 : (cnt + 1) % (1 << W);
  endtask
  task automatic idle_if();
    step('{0, 1'b0, 1'b0}, CR);
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    lit("rst_state", int'(state_o), 0);
    lit("rst_req", int'(mem_req_o), 0);
    lit("rst_irw", int'(ir_write_o), 0);
    lit("rst_pcw", int'(pc_write_o), 0);
    lit("rst_instret", int'(instret_o), 0);
    lit("rst_illegal", int'(illegal_o), 0);
    run(32'h002081B3, 0, 0, 0, 0);
    lit("r_len", last_len, 4);
    lit("r_regwr", last_rw, 1);
    idle_if();
    lit("r_instret", int'(instret_o), 1);
    run(32'h0000A183, 2, 2, 0, 0);
    lit("lw_len", last_len, 9);
    lit("lw_iord", last_iord, 3);
    run(32'h00208463, 0, 0, 1, 0);
    lit("beq1_len", last_len, 3);
    lit("beq1_regwr", last_rw, 0);
    run(32'h00208463, 0, 0, 0, 0);
    lit("beq0_len", last_len, 3);
    lit("beq0_regwr", last_rw, 0);
    run(32'h0020A023, 0, 0, 0, 0);
    lit("sw_len", last_len, 4);
    lit("sw_regwr", last_rw, 0);
    lit("sw_we", last_we, 1);
    run(32'h00108093, 1, 0, 0, 0);
    lit("addi_len", last_len, 5);
    run(32'h008000EF, 0, 0, 0, 0);
    lit("jal_len", last_len, 4);
    run(32'h000080E7, 0, 0, 0, 0);
    lit("jalr_len", last_len, 4);
    idle_if();
    lit("instret8", int'(instret_o), 8);
    run(32'h0020A023, 0, 1, 0, 1);
    idle_if();
    lit("abort_state", int'(state_o), 0);
    lit("abort_instret", int'(instret_o), 0);
    run(32'h0000007F, 0, 0, 0, 0);
    lit("ill_strobes", last_strb, 0);
    idle_if();
    lit("ill_rst_state", int'(state_o), 0);
    lit("ill_rst_illegal", int'(illegal_o), 0);
    repeat (15) run(32'h00208463, 0, 0, 1, 0);
    idle_if();
    lit("instret_max", int'(instret_o), 15);
    run(32'h002081B3, 0, 0, 0, 0);
    idle_if();
    lit("instret_wrap", int'(instret_o), 0);
    chk = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", c_cmp + l_cmp, c_fail + l_fail);
    $finish;
  end
endmodule
